// File: rtl/eth_rx_fetch.sv
// AXI read-side initiator that polls the Ethernet RX status, reads the frame byte
// count and drains the frame with one burst, forwarding beats as a backpressured stream.
module eth_rx_fetch #(
   parameter logic [31:0] ADDR_RX_EMPTY      = 32'h0,
   parameter logic [31:0] ADDR_RX_DATA_COUNT = 32'h0,
   parameter logic [31:0] ADDR_RX_DATA       = 32'h0,
   parameter int unsigned POLL_INTERVAL      = 64,
   parameter int unsigned MAX_BYTES          = 1536,
   parameter int unsigned TIMEOUT            = 1024
) (
   input  logic        clk_100_mhz,
   input  logic        rst,
   input  logic        enable,
   input  logic        err_clear,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   input  logic        rlast,
   output logic [31:0] frame_data,
   output logic        frame_valid,
   output logic        frame_last,
   input  logic        frame_ready,
   output logic [15:0] frame_len,
   output logic        busy,
   output logic [15:0] frames_count,
   output logic        err_oversize,
   output logic        err_timeout
);

   localparam int PW = $clog2(POLL_INTERVAL + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_INTERVAL - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [31:0]   MAX_B     = 32'(MAX_BYTES);

   typedef enum logic [2:0] {
      IDLE, POLL_WAIT, AR_STAT, AR_CNT, AR_DATA, R_STAT, R_CNT, R_DATA
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   poll_cnt_q;
   logic [TW-1:0]   tmo_cnt_q;
   logic            ar_state, r_state;
   logic            ar_hs, r_hs, any_hs;
   logic            tmo_hit, len_bad;
   logic            set_oversize;

   assign ar_state = (state_q == AR_STAT) || (state_q == AR_CNT) || (state_q == AR_DATA);
   assign r_state  = (state_q == R_STAT)  || (state_q == R_CNT)  || (state_q == R_DATA);
   assign ar_hs    = ar_state && arvalid && arready;
   assign r_hs     = r_state && rvalid && rready;
   assign any_hs   = ar_hs || r_hs;

   // Consecutive cycles without a handshake in any bus-waiting state.
   assign tmo_hit  = (ar_state || r_state) && !any_hs && (tmo_cnt_q == TMO_LAST);

   assign len_bad      = (rdata[15:0] == 16'd0) || ({16'd0, rdata[15:0]} > MAX_B);
   assign set_oversize = (state_q == R_CNT) && r_hs && len_bad;

   // State register
   always_ff @(posedge clk_100_mhz) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (enable) state_d = POLL_WAIT;
         POLL_WAIT: if (poll_cnt_q == '0) state_d = enable ? AR_STAT : IDLE;
         AR_STAT:   if (ar_hs) state_d = R_STAT;
         AR_CNT:    if (ar_hs) state_d = R_CNT;
         AR_DATA:   if (ar_hs) state_d = R_DATA;
         R_STAT:    if (r_hs) state_d = rdata[0] ? AR_CNT : POLL_WAIT;
         R_CNT:     if (r_hs) state_d = len_bad ? POLL_WAIT : AR_DATA;
         R_DATA:    if (r_hs && rlast) state_d = enable ? POLL_WAIT : IDLE;
         default:   state_d = IDLE;
      endcase
      if (tmo_hit) state_d = POLL_WAIT;
   end

   // Output logic: the data phase is a zero-latency pass-through of the R channel
   always_comb begin
      rready      = 1'b0;
      frame_valid = 1'b0;
      frame_last  = 1'b0;
      busy        = 1'b1;
      case (state_q)
         IDLE, POLL_WAIT: busy = 1'b0;
         R_STAT, R_CNT:   rready = 1'b1;
         R_DATA: begin
            rready      = frame_ready;
            frame_valid = rvalid;
            frame_last  = rvalid && rlast;
         end
         default: ;
      endcase
   end

   assign frame_data = rdata;

   // Poll and timeout counters
   always_ff @(posedge clk_100_mhz) begin
      if (rst) begin
         poll_cnt_q <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         if (state_d == POLL_WAIT && state_q != POLL_WAIT)
            poll_cnt_q <= POLL_LOAD;
         else if (state_q == POLL_WAIT && poll_cnt_q != '0)
            poll_cnt_q <= poll_cnt_q - 1'b1;

         if (state_d != state_q || any_hs)
            tmo_cnt_q <= '0;
         else if (ar_state || r_state)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   // AR channel: arvalid rises one cycle after entering an AR state and drops
   // when the state is left (handshake or timeout); araddr settles alongside it.
   always_ff @(posedge clk_100_mhz) begin
      if (rst) begin
         arvalid <= 1'b0;
         araddr  <= '0;
      end else begin
         arvalid <= (state_d == state_q) &&
                    (state_d == AR_STAT || state_d == AR_CNT || state_d == AR_DATA);
         case (state_q)
            AR_STAT: araddr <= ADDR_RX_EMPTY;
            AR_CNT:  araddr <= ADDR_RX_DATA_COUNT;
            AR_DATA: araddr <= ADDR_RX_DATA;
            default: ;
         endcase
      end
   end

   // Frame bookkeeping and sticky errors (a new error beats err_clear)
   always_ff @(posedge clk_100_mhz) begin
      if (rst) begin
         frame_len    <= '0;
         frames_count <= '0;
         err_oversize <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (state_q == R_CNT && r_hs)
            frame_len <= rdata[15:0];
         if (state_q == R_DATA && r_hs && rlast)
            frames_count <= frames_count + 16'd1;
         err_oversize <= set_oversize || (err_oversize && !err_clear);
         err_timeout  <= tmo_hit      || (err_timeout  && !err_clear);
      end
   end

endmodule

// File: tb/tb_eth_rx_fetch.sv
// Directed bench for eth_rx_fetch: a small behavioural AXI read slave plus stream sink,
// with one task per scenario doing its own inline checks.
`timescale 1ns/1ps
module tb_eth_rx_fetch;
   localparam logic [31:0] A_EMPTY = 32'h0000_0100;
   localparam logic [31:0] A_CNT   = 32'h0000_0104;
   localparam logic [31:0] A_DATA  = 32'h0000_0108;
   localparam logic [31:0] D_BASE  = 32'hA5A5_0000;

   logic        clk_100_mhz = 1'b0;
   logic        rst, enable, err_clear, arready, rvalid, rlast, frame_ready;
   logic [31:0] rdata;
   logic [31:0] araddr, frame_data;
   logic        arvalid, rready, frame_valid, frame_last, busy, err_oversize, err_timeout;
   logic [15:0] frame_len, frames_count;

   eth_rx_fetch #(
      .ADDR_RX_EMPTY(A_EMPTY), .ADDR_RX_DATA_COUNT(A_CNT), .ADDR_RX_DATA(A_DATA),
      .POLL_INTERVAL(8), .MAX_BYTES(1536), .TIMEOUT(16)
   ) dut (
      .clk_100_mhz(clk_100_mhz), .rst(rst), .enable(enable), .err_clear(err_clear),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast),
      .frame_data(frame_data), .frame_valid(frame_valid), .frame_last(frame_last),
      .frame_ready(frame_ready), .frame_len(frame_len), .busy(busy),
      .frames_count(frames_count), .err_oversize(err_oversize), .err_timeout(err_timeout)
   );

   always #5 clk_100_mhz = ~clk_100_mhz;

   int tests = 0;
   int fails = 0;

   logic [31:0] status, count, cur_addr, ar_addr_s;
   int          n_beats, beat, cyc;
   bit          rv_on, mute, bp_mode, ar_hs, r_hs;
   bit [3:0]    bp_pat;
   logic [31:0] ar_addrs[$];
   int          ar_t[$];
   logic [31:0] rx_q[$];
   bit          rx_last[$];
   bit          busy_log[0:4095];
   int          fv_seen, mirror_err;

   // One clock cycle: slave reacts to the previous edge, then everything is sampled
   // before the coming edge.
   task automatic cycle();
      if (r_hs) begin
         if (cur_addr == A_DATA && beat < n_beats - 1) beat++;
         else rv_on = 1'b0;
      end
      if (ar_hs) begin
         cur_addr = ar_addr_s;
         beat     = 0;
         rv_on    = !mute;
      end
      frame_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
      rvalid = rv_on;
      rlast  = rv_on && (cur_addr != A_DATA || beat == n_beats - 1);
      rdata  = (cur_addr == A_EMPTY) ? status : (cur_addr == A_CNT) ? count : D_BASE + 32'(beat);
      #1;
      ar_hs     = arvalid && arready;
      ar_addr_s = araddr;
      r_hs      = rvalid && rready;
      if (ar_hs) begin
         ar_addrs.push_back(araddr);
         ar_t.push_back(cyc);
      end
      if (frame_valid) begin
         fv_seen++;
         if (rready !== frame_ready) mirror_err++;
      end
      if (frame_valid && frame_ready) begin
         rx_q.push_back(frame_data);
         rx_last.push_back(frame_last);
      end
      busy_log[cyc % 4096] = busy;
      cyc++;
      @(negedge clk_100_mhz);
   endtask

   task automatic clear_logs();
      rv_on = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
      ar_addrs.delete(); ar_t.delete(); rx_q.delete(); rx_last.delete();
      fv_seen = 0; mirror_err = 0;
   endtask

   task automatic restart();
      rst = 1'b1;
      cycle(); cycle();
      clear_logs();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0;
      cycle(); cycle();
      tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid got %b exp 0", arvalid); end
      tests++; if (araddr !== 32'h0) begin fails++; $display("FAIL reset_araddr got %h exp 0", araddr); end
      tests++; if (rready !== 1'b0) begin fails++; $display("FAIL reset_rready got %b exp 0", rready); end
      tests++; if (frame_valid !== 1'b0 || frame_last !== 1'b0) begin fails++; $display("FAIL reset_frame got v=%b l=%b exp 0 0", frame_valid, frame_last); end
      tests++; if (frame_len !== 16'h0 || frames_count !== 16'h0) begin fails++; $display("FAIL reset_counts got len=%0d cnt=%0d exp 0 0", frame_len, frames_count); end
      tests++; if (err_oversize !== 1'b0 || err_timeout !== 1'b0) begin fails++; $display("FAIL reset_errs got %b%b exp 00", err_oversize, err_timeout); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      clear_logs();
      rst = 1'b0;
   endtask

   task automatic test_no_frame();
      int bad, bs;
      enable = 1'b1; status = 32'h0; restart();
      repeat (45) cycle();
      bad = 0;
      foreach (ar_addrs[i]) if (ar_addrs[i] !== A_EMPTY) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL no_frame_addr got %0d non-status ARs exp 0", bad); end
      tests++; if (fv_seen != 0) begin fails++; $display("FAIL no_frame_valid got %0d cycles exp 0", fv_seen); end
      tests++;
      if (ar_t.size() < 3) begin
         fails++; $display("FAIL no_frame_polls got %0d ARs exp >=3", ar_t.size());
      end else begin
         tests++; if (ar_t[1] - ar_t[0] != 11) begin fails++; $display("FAIL no_frame_period got %0d exp 11", ar_t[1] - ar_t[0]); end
         tests++; if (ar_t[2] - ar_t[1] != 11) begin fails++; $display("FAIL no_frame_period2 got %0d exp 11", ar_t[2] - ar_t[1]); end
         bs = 0;
         for (int c = ar_t[1] + 1; c <= ar_t[2]; c++) bs += int'(busy_log[c % 4096]);
         tests++; if (bs != 3) begin fails++; $display("FAIL no_frame_busy got %0d busy cycles exp 3", bs); end
      end
   endtask

   task automatic check_frame(input string tag, input int nb);
      int bad_w, bad_l;
      tests++; if (rx_q.size() != nb) begin fails++; $display("FAIL %s_words got %0d exp %0d", tag, rx_q.size(), nb); end
      bad_w = 0; bad_l = 0;
      foreach (rx_q[i]) begin
         if (rx_q[i] !== D_BASE + 32'(i)) bad_w++;
         if (rx_last[i] != (i == nb - 1)) bad_l++;
      end
      tests++; if (bad_w != 0) begin fails++; $display("FAIL %s_order got %0d bad words exp 0", tag, bad_w); end
      tests++; if (bad_l != 0) begin fails++; $display("FAIL %s_last got %0d bad last flags exp 0", tag, bad_l); end
   endtask

   task automatic test_one_frame();
      enable = 1'b1; status = 32'h1; count = 32'd64; n_beats = 18; restart();
      for (int i = 0; i < 120 && frames_count !== 16'd1; i++) cycle();
      status = 32'h0;
      tests++; if (frames_count !== 16'd1) begin fails++; $display("FAIL frame_count got %0d exp 1", frames_count); end
      check_frame("frame", 18);
      tests++; if (frame_len !== 16'd64) begin fails++; $display("FAIL frame_len got %0d exp 64", frame_len); end
      tests++;
      if (ar_addrs.size() != 3 || ar_addrs[0] !== A_EMPTY || ar_addrs[1] !== A_CNT || ar_addrs[2] !== A_DATA) begin
         fails++; $display("FAIL frame_ar_seq got %0d ARs exp status,count,data", ar_addrs.size());
      end
   endtask

   task automatic test_backpressure();
      enable = 1'b1; status = 32'h1; count = 32'd16; n_beats = 6;
      bp_pat = 4'b1001; bp_mode = 1'b1; restart();
      for (int i = 0; i < 150 && frames_count !== 16'd1; i++) cycle();
      status = 32'h0; bp_mode = 1'b0;
      tests++; if (frames_count !== 16'd1) begin fails++; $display("FAIL bp_count got %0d exp 1", frames_count); end
      check_frame("bp", 6);
      tests++; if (mirror_err != 0) begin fails++; $display("FAIL bp_rready got %0d mismatching cycles exp 0", mirror_err); end
      tests++; if (fv_seen <= 6) begin fails++; $display("FAIL bp_stall got %0d valid cycles exp >6", fv_seen); end
   endtask

   task automatic test_oversize();
      int n_data, n_stat;
      enable = 1'b1; status = 32'h1; count = 32'd2000; restart();
      for (int i = 0; i < 60 && err_oversize !== 1'b1; i++) cycle();
      status = 32'h0;
      tests++; if (err_oversize !== 1'b1) begin fails++; $display("FAIL ovs_flag got %b exp 1", err_oversize); end
      tests++; if (frame_len !== 16'd2000) begin fails++; $display("FAIL ovs_len got %0d exp 2000", frame_len); end
      repeat (30) cycle();
      n_data = 0; n_stat = 0;
      foreach (ar_addrs[i]) begin
         if (ar_addrs[i] === A_DATA) n_data++;
         if (ar_addrs[i] === A_EMPTY) n_stat++;
      end
      tests++; if (n_data != 0) begin fails++; $display("FAIL ovs_no_data got %0d data ARs exp 0", n_data); end
      tests++; if (n_stat < 2) begin fails++; $display("FAIL ovs_repoll got %0d status ARs exp >=2", n_stat); end
      tests++; if (err_oversize !== 1'b1) begin fails++; $display("FAIL ovs_sticky got %b exp 1", err_oversize); end
      err_clear = 1'b1; cycle(); err_clear = 1'b0;
      tests++; if (err_oversize !== 1'b0) begin fails++; $display("FAIL ovs_clear got %b exp 0", err_oversize); end

      status = 32'h1; count = 32'd0; restart();
      for (int i = 0; i < 60 && err_oversize !== 1'b1; i++) cycle();
      tests++; if (err_oversize !== 1'b1) begin fails++; $display("FAIL len_zero got %b exp 1", err_oversize); end

      count = 32'd1537; restart();
      for (int i = 0; i < 60 && err_oversize !== 1'b1; i++) cycle();
      tests++; if (err_oversize !== 1'b1) begin fails++; $display("FAIL len_1537 got %b exp 1", err_oversize); end

      count = 32'd1536; n_beats = 3; restart();
      for (int i = 0; i < 80 && frames_count !== 16'd1; i++) cycle();
      status = 32'h0;
      tests++; if (frames_count !== 16'd1 || frame_len !== 16'd1536) begin fails++; $display("FAIL len_max got cnt=%0d len=%0d exp 1 1536", frames_count, frame_len); end
      tests++; if (err_oversize !== 1'b0) begin fails++; $display("FAIL len_max_err got %b exp 0", err_oversize); end
   endtask

   task automatic test_timeout();
      int t_err;
      enable = 1'b1; status = 32'h1; mute = 1'b1; restart();
      for (int i = 0; i < 80 && err_timeout !== 1'b1; i++) cycle();
      t_err = cyc;
      tests++;
      if (err_timeout !== 1'b1 || ar_t.size() < 1) begin
         fails++; $display("FAIL tmo_flag got %b with %0d ARs exp 1", err_timeout, ar_t.size());
      end else begin
         tests++; if (t_err - ar_t[0] != 17) begin fails++; $display("FAIL tmo_delay got %0d exp 17", t_err - ar_t[0]); end
         tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL tmo_arvalid got %b exp 0", arvalid); end
         for (int i = 0; i < 40 && ar_t.size() < 2; i++) cycle();
         tests++;
         if (ar_t.size() < 2) begin
            fails++; $display("FAIL tmo_repoll got %0d ARs exp 2", ar_t.size());
         end else begin
            tests++; if (ar_t[1] - t_err != 9 || ar_addrs[1] !== A_EMPTY) begin fails++; $display("FAIL tmo_repoll_time got %0d addr %h exp 9 %h", ar_t[1] - t_err, ar_addrs[1], A_EMPTY); end
         end
      end
      mute = 1'b0; status = 32'h0;
   endtask

   task automatic test_reset_mid_burst();
      enable = 1'b1; status = 32'h1; count = 32'd64; n_beats = 18; restart();
      for (int i = 0; i < 100 && rx_q.size() < 5; i++) cycle();
      tests++; if (rx_q.size() != 5) begin fails++; $display("FAIL mid_beats got %0d exp 5", rx_q.size()); end
      rst = 1'b1; cycle();
      tests++; if (arvalid !== 1'b0 || araddr !== 32'h0 || rready !== 1'b0) begin fails++; $display("FAIL mid_rst_ar got arv=%b addr=%h rr=%b exp 0 0 0", arvalid, araddr, rready); end
      tests++; if (frame_valid !== 1'b0 || frame_last !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst_stream got v=%b l=%b busy=%b exp 0 0 0", frame_valid, frame_last, busy); end
      tests++; if (frame_len !== 16'h0 || frames_count !== 16'h0) begin fails++; $display("FAIL mid_rst_cnt got len=%0d cnt=%0d exp 0 0", frame_len, frames_count); end
      clear_logs(); status = 32'h0; rst = 1'b0;
      for (int i = 0; i < 40 && ar_t.size() < 1; i++) cycle();
      tests++; if (ar_addrs.size() < 1 || ar_addrs[0] !== A_EMPTY) begin fails++; $display("FAIL mid_first_ar got %0d ARs exp first at %h", ar_addrs.size(), A_EMPTY); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; err_clear = 1'b0; arready = 1'b1;
      rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; frame_ready = 1'b1;
      status = 32'h0; count = 32'h0; cur_addr = 32'h0; ar_addr_s = 32'h0;
      n_beats = 1; beat = 0; cyc = 0; mute = 1'b0; bp_mode = 1'b0; bp_pat = 4'b1111;
      clear_logs();
      @(negedge clk_100_mhz);
      test_reset();
      test_no_frame();
      test_one_frame();
      test_backpressure();
      test_oversize();
      test_timeout();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
